// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports with scoreboard busy bits, writeback, issue and clear control.
interface reg_file_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [XLEN-1:0] rd_data_a;
    logic [XLEN-1:0] rd_data_b;
    logic            busy_a;
    logic            busy_b;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            clr_req;
    logic            clr_busy;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        input  rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        output rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Architectural register file with per-register busy scoreboard and a clear sweep
// that zeroes one entry per cycle.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int unsigned AW       = $clog2(NREGS);
    localparam bit          HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   idx_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic wr_fire_c;
    logic iss_fire_c;
    logic clr_start_c;
    logic sweep_c;
    logic byp_en_c;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return HAS_ZERO && (a == '0);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.clr_req) state_d = ST_SWEEP;
            ST_SWEEP: if (idx_q == AW'(NREGS - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control decode; clr_req in IDLE drops a coincident write/issue
    always_comb begin
        wr_fire_c    = 1'b0;
        iss_fire_c   = 1'b0;
        clr_start_c  = 1'b0;
        sweep_c      = 1'b0;
        byp_en_c     = 1'b0;
        bus.clr_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_start_c = bus.clr_req;
                wr_fire_c   = bus.wr_en  && !bus.clr_req && !is_zero(bus.wr_addr);
                iss_fire_c  = bus.iss_en && !bus.clr_req && !is_zero(bus.iss_addr);
                byp_en_c    = bus.wr_en && !is_zero(bus.wr_addr);
            end
            ST_SWEEP: begin
                sweep_c      = 1'b1;
                bus.clr_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Busy update; issue applied after writeback so a new producer wins
    always_comb begin
        busy_d = busy_q;
        if (clr_start_c) begin
            busy_d = '0;
        end else begin
            if (wr_fire_c)  busy_d[bus.wr_addr]  = 1'b0;
            if (iss_fire_c) busy_d[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             idx_q <= '0;
        else if (clr_start_c) idx_q <= '0;
        else if (sweep_c)     idx_q <= idx_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (sweep_c) begin
            regs_q[idx_q] <= '0;
        end else if (wr_fire_c) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Combinational read ports with same-cycle writeback bypass
    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        if (byp_en_c && (bus.wr_addr == bus.rd_addr_a)) bus.rd_data_a = bus.wr_data;
        if (byp_en_c && (bus.wr_addr == bus.rd_addr_b)) bus.rd_data_b = bus.wr_data;
        if (is_zero(bus.rd_addr_a)) bus.rd_data_a = '0;
        if (is_zero(bus.rd_addr_b)) bus.rd_data_b = '0;
        bus.busy_a = busy_q[bus.rd_addr_a];
        bus.busy_b = busy_q[bus.rd_addr_b];
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default config checked against an array model,
// plus a short directed run on a 16 x 64-bit instance without a zero register.
module tb_reg_file_sb;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
    reg_file_sb_if #(.XLEN(64),   .NREGS(16))    bus2 ();

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        logic        cb;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    // Reference model: plain arrays plus a count of sweep cycles still to run
    logic [31:0] m_regs [NREGS];
    logic        m_busy [NREGS];
    int          sweep_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        sweep_left = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 0) return '0;
        if (sweep_left == 0 && we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    task automatic m_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ie, input logic [4:0] ia, input logic cr);
        if (!rst) begin
            m_reset();
        end else if (sweep_left > 0) begin
            m_regs[NREGS - sweep_left] = '0;
            sweep_left--;
        end else if (cr) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            sweep_left = NREGS;
        end else begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (ie && ia != 0) m_busy[ia] = 1'b1;
        end
    endtask

    // One cycle: drive at posedge+1, queue expected outputs, advance model at the edge
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic cr,
                         input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.iss_en = ie; bus.iss_addr = ia; bus.clr_req = cr;
        bus.rd_addr_a = ra; bus.rd_addr_b = rb;
        e.a   = m_read(ra, we, wa, wd);
        e.b   = m_read(rb, we, wa, wd);
        e.ba  = m_busy[ra];
        e.bb  = m_busy[rb];
        e.cb  = (sweep_left > 0);
        e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        m_step(we, wa, wd, ie, ia, cr);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, ra, rb);
    endtask

    task automatic rand_cycle(input bit allow_clr);
        logic [4:0] wa;
        logic [4:0] rb;
        wa = 5'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
        drive(1'($urandom), wa, $urandom, 1'($urandom), 5'($urandom),
              allow_clr && ($urandom_range(0, 99) == 0), 5'($urandom), rb);
    endtask

    // Monitor: outputs are valid every cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.rd_data_a !== e.a) $display("FAIL rd_data_a cyc %0d: got %h expected %h", e.cyc, bus.rd_data_a, e.a);
            if (bus.rd_data_b !== e.b) $display("FAIL rd_data_b cyc %0d: got %h expected %h", e.cyc, bus.rd_data_b, e.b);
            if (bus.busy_a !== e.ba)   $display("FAIL busy_a cyc %0d: got %b expected %b", e.cyc, bus.busy_a, e.ba);
            if (bus.busy_b !== e.bb)   $display("FAIL busy_b cyc %0d: got %b expected %b", e.cyc, bus.busy_b, e.bb);
            if (bus.clr_busy !== e.cb) $display("FAIL clr_busy cyc %0d: got %b expected %b", e.cyc, bus.clr_busy, e.cb);
            n_chk++;
            if (bus.rd_data_a === e.a && bus.rd_data_b === e.b && bus.busy_a === e.ba &&
                bus.busy_b === e.bb && bus.clr_busy === e.cb) n_pass++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b0;
        m_reset();
        bus2.rd_addr_a = '0; bus2.rd_addr_b = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0;
        bus2.wr_data = '0; bus2.iss_en = 1'b0; bus2.iss_addr = '0; bus2.clr_req = 1'b0;
        @(posedge clk); #1;
        idle(5'd5, 5'd7);
        idle(5'd0, 5'd31);
        rst = 1'b1;

        // Write then read back, and same-cycle bypass on both ports
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1);
        idle(5'd5, 5'd5);
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        idle(5'd0, 5'd7);

        // Issue / writeback interaction on x3, and x0 never busy
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        idle(5'd3, 5'd3);
        drive(1'b1, 5'd3, 32'hA0A0A0A0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        drive(1'b1, 5'd3, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd3, 5'd0);
        idle(5'd0, 5'd3);

        // Fill, mark x4 busy, clear together with a write/issue that must be dropped
        for (int i = 0; i < NREGS; i++) drive(1'b1, 5'(i), $urandom | 32'd1, 1'b0, 5'd0, 1'b0, 5'(i), 5'd4);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd9);
        idle(5'd4, 5'd9);
        drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 1'b1, 5'd4, 5'd9);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.clr_busy === 1'b1) cnt++;
            rand_cycle(1'b1);
            if (sweep_left == 0 && bus.clr_busy === 1'b0 && k >= NREGS) break;
        end
        chk("sweep_len_32", 64'(cnt), 64'(NREGS));
        for (int i = 0; i < NREGS; i += 2) idle(5'(i), 5'(i + 1));

        // Reset in the middle of a sweep
        for (int i = 1; i < NREGS; i++) drive(1'b1, 5'(i), $urandom | 32'd1, 1'b0, 5'd0, 1'b0, 5'(i), 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0, 5'd20, 5'd20);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd20);
        for (int k = 0; k < 10; k++) idle(5'd20, 5'(k));
        bus.rd_addr_a = 5'd20;
        bus.rd_addr_b = 5'd31;
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
        chk("rst_rd_a_x20", 64'(bus.rd_data_a), 64'd0);
        chk("rst_rd_b_x31", 64'(bus.rd_data_b), 64'd0);
        chk("rst_busy_x20", 64'(bus.busy_a), 64'd0);
        @(posedge clk); #1;
        idle(5'd20, 5'd31);
        rst = 1'b1;
        for (int i = 0; i < NREGS; i += 2) idle(5'(i), 5'(i + 1));

        // Random traffic
        for (int k = 0; k < 2000; k++) rand_cycle(1'b1);
        for (int k = 0; k < NREGS + 2; k++) idle(5'(k), 5'(NREGS - 1 - k));

        // 16 x 64-bit instance with a writable, busy-capable x0
        bus2.wr_en = 1'b1; bus2.wr_addr = 4'd0; bus2.wr_data = 64'hA5A5_5A5A_0123_4567;
        bus2.rd_addr_a = 4'd0;
        #1;
        chk("p2_bypass_x0", bus2.rd_data_a, 64'hA5A5_5A5A_0123_4567);
        @(posedge clk); #1;
        bus2.wr_en = 1'b0;
        chk("p2_stored_x0", bus2.rd_data_a, 64'hA5A5_5A5A_0123_4567);
        bus2.iss_en = 1'b1; bus2.iss_addr = 4'd0;
        @(posedge clk); #1;
        bus2.iss_en = 1'b0;
        chk("p2_busy_x0", 64'(bus2.busy_a), 64'd1);
        bus2.clr_req = 1'b1;
        @(posedge clk); #1;
        bus2.clr_req = 1'b0;
        chk("p2_busy_cleared", 64'(bus2.busy_a), 64'd0);
        cnt = 0;
        for (int k = 0; k < 100 && bus2.clr_busy === 1'b1; k++) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("p2_sweep_len_16", 64'(cnt), 64'd16);
        chk("p2_x0_cleared", bus2.rd_data_a, 64'd0);

        @(negedge clk); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits (>=8).
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, 4..64); AW = log2(NREGS).
REQ-003 Parameter ZERO_REG, default 1; 1 makes register 0 hardwired to zero, 0 makes it a normal register.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rd_addr_a, rd_addr_b  in  AW  read port A/B register index.
REQ-007 rd_data_a, rd_data_b  out  XLEN  read port A/B data.
REQ-008 busy_a, busy_b  out  1  scoreboard busy bit of rd_addr_a / rd_addr_b.
REQ-009 wr_en  in  1  writeback strobe.
REQ-010 wr_addr  in  AW  writeback destination index.
REQ-011 wr_data  in  XLEN  writeback data.
REQ-012 iss_en  in  1  issue strobe, reserves a destination.
REQ-013 iss_addr  in  AW  destination index being reserved.
REQ-014 clr_req  in  1  single-cycle pulse requesting a full-array clear sweep.
REQ-015 clr_busy  out  1  high while the clear sweep is in progress.

Function
REQ-016 Storage SHALL be NREGS x XLEN registers plus an NREGS-bit busy vector.
REQ-017 Read ports SHALL be combinational: rd_data_x = regs[rd_addr_x].
REQ-018 Write-through bypass: in IDLE, if wr_en and wr_addr == rd_addr_x (and not the zero register), rd_data_x SHALL equal wr_data in the same cycle.
REQ-019 With ZERO_REG=1, index 0 SHALL read 0, ignore writes, and never be marked busy; busy_x for index 0 SHALL be 0.
REQ-020 In IDLE, wr_en SHALL write wr_data into regs[wr_addr] at the next rising edge.
REQ-021 Issue: in IDLE, iss_en SHALL set busy[iss_addr] at the next edge.
REQ-022 Writeback: in IDLE, wr_en SHALL clear busy[wr_addr] at the next edge.
REQ-023 Simultaneous iss_en and wr_en to the same index SHALL leave busy set (new producer wins); the data write still occurs.
REQ-024 busy_x SHALL be combinational from the stored busy vector (no bypass of same-cycle issue or writeback).
REQ-025 FSM states: IDLE, SWEEP.
REQ-026 IDLE -> SWEEP when clr_req=1; at that edge the entire busy vector SHALL clear and the sweep index SHALL load 0.
REQ-027 In SWEEP, each cycle SHALL write 0 to regs[index] and increment the index by 1; the transition to IDLE SHALL occur on the edge that clears index NREGS-1, giving exactly NREGS cycles with clr_busy=1.
REQ-028 clr_busy SHALL be 1 iff state is SWEEP.
REQ-029 In SWEEP, wr_en, iss_en and clr_req SHALL be ignored (no data write, no busy change, no restart), and bypass SHALL be disabled.
REQ-030 In SWEEP, reads SHALL return stored contents (already-swept entries read 0).
REQ-031 A clr_req asserted together with wr_en/iss_en in IDLE SHALL take priority; the write and issue SHALL be dropped.

Reset
REQ-032 While rst=0, all registers SHALL be 0, the busy vector 0, state IDLE, sweep index 0, clr_busy 0.
REQ-033 rst assertion mid-sweep SHALL abort the sweep immediately (asynchronously) to IDLE with all of the REQ-032 values.
REQ-034 The first functional edge SHALL be the first rising clk edge after rst deasserts.

Verification
REQ-035 Reset, write x5=0xDEADBEEF, read A=5 next cycle -> rd_data_a=0xDEADBEEF, busy_a=0.
REQ-036 Same cycle wr_en x7=0x12345678 with rd_addr_b=7 -> rd_data_b=0x12345678 combinationally; write x0=0xFFFFFFFF -> x0 reads 0.
REQ-037 iss_en x3 -> busy_a(3)=1 next cycle; wr_en x3 with iss_en x3 in the same cycle -> busy stays 1; lone wr_en x3 -> busy 0.
REQ-038 Fill all registers non-zero, mark x4 busy, pulse clr_req -> clr_busy high for exactly 32 cycles, busy_a(4)=0 after the entry edge, all reads 0 after completion; wr_en/iss_en during the sweep have no effect.
REQ-039 Assert rst at sweep cycle 10 -> clr_busy=0 immediately, all registers 0, IDLE after release.
REQ-040 NREGS=16, XLEN=64, ZERO_REG=0 -> x0 writable and can be marked busy, sweep lasts 16 cycles.
